// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int X0_ADDR    = 0;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } hz_state_e;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard detection plus a pipeline freeze FSM for outstanding
// data-memory accesses, with a wait watchdog and saturating event counters.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   input  logic              rs1_used_i,
   input  logic              rs2_used_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              mem_req_i,
   input  logic              mem_ready_i,
   output logic              pc_write_o,
   output logic              ifid_stall_o,
   output logic              noop_o,
   output logic              freeze_o,
   output logic              timeout_o,
   output logic [CNT_W-1:0]  lu_cnt_o,
   output logic [CNT_W-1:0]  frz_cnt_o
);

   localparam int WCW = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT_C = WCW'(TIMEOUT);
   localparam logic [WCW-1:0] ONE_C     = WCW'(1);

   hz_state_e      state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           timeout_q, timeout_d;
   logic           freeze_raw;
   logic           freeze_c;
   logic           lu_hit;
   logic           noop_c;

   assign lu_hit = ex_memread_i && (ex_rd_i != REG_AW'(X0_ADDR)) &&
                   ((rs1_used_i && (rs1_addr_i == ex_rd_i)) ||
                    (rs2_used_i && (rs2_addr_i == ex_rd_i)));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      freeze_raw = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               freeze_raw = 1'b1;
               state_d    = ST_WAIT;
               wait_cnt_d = ONE_C;
            end
         end
         ST_WAIT: begin
            // The abort cycle itself is not frozen, so a timed-out access
            // holds the pipe for exactly TIMEOUT cycles.
            if (mem_ready_i) begin
               state_d = ST_RUN;
            end else if (wait_cnt_q == TIMEOUT_C) begin
               state_d   = ST_RUN;
               timeout_d = 1'b1;
            end else begin
               freeze_raw = 1'b1;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // A freeze holds every stage, so the bubble is masked and the hit
   // is simply seen again once the freeze lifts.
   assign freeze_c = freeze_raw && !rst_i;
   assign noop_c   = lu_hit && !freeze_c && !rst_i;

   assign freeze_o     = freeze_c;
   assign noop_o       = noop_c;
   assign ifid_stall_o = noop_c;
   assign pc_write_o   = !freeze_c && !noop_c;
   assign timeout_o    = timeout_q;

   sat_counter #(
      .W (CNT_W)
   ) u_lu_cnt (
      .clk_i   (clk_i),
      .clear_i (rst_i),
      .inc_i   (noop_c),
      .cnt_o   (lu_cnt_o)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_frz_cnt (
      .clk_i   (clk_i),
      .clear_i (rst_i),
      .inc_i   (freeze_c),
      .cnt_o   (frz_cnt_o)
   );

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed literal checks plus random stimulus
// compared every cycle against a behavioural model.
module tb_hazard_ctrl_unit;

   localparam int AW  = 5;
   localparam int TO  = 4;
   localparam int CW  = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1, rs2, ex_rd;
   logic          u1, u2, memrd, req, rdy;
   logic          pc_write, ifid_stall, noop, freeze, tout;
   logic [CW-1:0] lu_cnt, frz_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_wait    = 1'b0;
   int m_elapsed = 0;
   bit m_to      = 1'b0;
   int m_lu      = 0;
   int m_frz     = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(
      .REG_AW  (AW),
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rs1_addr_i   (rs1),
      .rs2_addr_i   (rs2),
      .rs1_used_i   (u1),
      .rs2_used_i   (u2),
      .ex_memread_i (memrd),
      .ex_rd_i      (ex_rd),
      .mem_req_i    (req),
      .mem_ready_i  (rdy),
      .pc_write_o   (pc_write),
      .ifid_stall_o (ifid_stall),
      .noop_o       (noop),
      .freeze_o     (freeze),
      .timeout_o    (tout),
      .lu_cnt_o     (lu_cnt),
      .frz_cnt_o    (frz_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference: compare outputs against the model, then advance the model.
   always @(negedge clk) begin
      bit hit, e_frz, e_noop, e_pc;
      hit = memrd && (ex_rd != 0) &&
            ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
      if (rst)         e_frz = 1'b0;
      else if (!m_wait) e_frz = req && !rdy;
      else             e_frz = !rdy && (m_elapsed < TO);
      e_noop = !rst && !e_frz && hit;
      e_pc   = !e_frz && !e_noop;

      chk("m_pc_write", pc_write, e_pc);
      chk("m_ifid_stall", ifid_stall, e_noop);
      chk("m_noop", noop, e_noop);
      chk("m_freeze", freeze, e_frz);
      chk("m_timeout", tout, m_to);
      chk("m_lu_cnt", lu_cnt, m_lu);
      chk("m_frz_cnt", frz_cnt, m_frz);

      if (rst) begin
         m_wait = 0; m_elapsed = 0; m_to = 0; m_lu = 0; m_frz = 0;
      end else begin
         if (e_noop && m_lu < MAXC) m_lu++;
         if (e_frz && m_frz < MAXC) m_frz++;
         if (!m_wait) begin
            if (e_frz) begin
               m_wait = 1; m_elapsed = 1;
            end
         end else if (e_frz) begin
            m_elapsed++;
         end else begin
            // wait ended: ready arrived, or the watchdog gave up
            m_wait = 0;
            if (!rdy) m_to = 1;
         end
      end
   end

   task automatic cycle(input logic r, input logic q, input logic y, input logic mr,
                        input logic [AW-1:0] rd, input logic [AW-1:0] a1, input logic e1,
                        input logic [AW-1:0] a2, input logic e2);
      @(posedge clk);
      #1;
      rst = r; req = q; rdy = y; memrd = mr; ex_rd = rd;
      rs1 = a1; u1 = e1; rs2 = a2; u2 = e2;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input logic r);
      cycle(r, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic hit_cyc(input logic q, input logic y);
      cycle(0, q, y, 1, 5, 0, 0, 5, 1);
   endtask

   initial begin
      rst = 1; req = 0; rdy = 0; memrd = 0; ex_rd = 0;
      rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;

      // reset masks a pending hazard and memory request
      cycle(1, 1, 0, 1, 5, 0, 0, 5, 1);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_noop", noop, 0);
      chk("rst_freeze", freeze, 0);
      idle(0);
      chk("rst_lu_cnt", lu_cnt, 0);
      chk("rst_frz_cnt", frz_cnt, 0);
      chk("rst_timeout", tout, 0);

      // load-use via rs2
      hit_cyc(0, 0);
      chk("lu_pc_write", pc_write, 0);
      chk("lu_stall", ifid_stall, 1);
      chk("lu_noop", noop, 1);
      idle(0);
      chk("lu_one_cycle", noop, 0);
      chk("lu_cnt_1", lu_cnt, 1);

      // x0 and unused-operand filtering
      cycle(0, 0, 0, 1, 0, 0, 1, 0, 0);
      chk("flt_x0", noop, 0);
      cycle(0, 0, 0, 1, 7, 7, 0, 0, 0);
      chk("flt_unused", noop, 0);

      // 3-cycle memory wait with a coincident load-use hit
      hit_cyc(1, 0);
      chk("mw_freeze0", freeze, 1);
      chk("mw_noop0", noop, 0);
      chk("mw_pc0", pc_write, 0);
      hit_cyc(0, 0);
      chk("mw_freeze1", freeze, 1);
      hit_cyc(0, 0);
      chk("mw_freeze2", freeze, 1);
      chk("mw_noop2", noop, 0);
      hit_cyc(0, 1);
      chk("mw_freeze3", freeze, 0);
      chk("mw_noop_after", noop, 1);
      chk("mw_frz_cnt", frz_cnt, 3);
      idle(0);
      chk("mw_lu_cnt", lu_cnt, 2);

      // watchdog abort after TIMEOUT frozen cycles
      idle(1);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("to_freeze0", freeze, 1);
      idle(0);
      idle(0);
      idle(0);
      chk("to_freeze3", freeze, 1);
      chk("to_no_flag_yet", tout, 0);
      idle(0);
      chk("to_abort_freeze", freeze, 0);
      chk("to_abort_pc", pc_write, 1);
      idle(0);
      chk("to_flag", tout, 1);
      chk("to_back_in_run", freeze, 0);
      chk("to_frz_sat", frz_cnt, 3);
      idle(0);
      chk("to_sticky", tout, 1);

      // reset in the second wait cycle
      idle(1);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      chk("rmw_freeze", freeze, 0);
      chk("rmw_pc", pc_write, 1);
      idle(0);
      chk("rmw_run", freeze, 0);
      chk("rmw_frz_cnt", frz_cnt, 0);
      chk("rmw_timeout", tout, 0);

      // request and ready together in RUN
      cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("rr_freeze", freeze, 0);
      idle(0);
      chk("rr_still_run", freeze, 0);

      // saturation of the load-use counter
      for (int i = 0; i < 5; i++) begin
         hit_cyc(0, 0);
         idle(0);
      end
      chk("sat_lu_cnt", lu_cnt, 3);

      // random phase
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst   = ($urandom_range(0, 99) < 3);
         req   = ($urandom_range(0, 99) < 40);
         rdy   = ($urandom_range(0, 99) < 25);
         memrd = ($urandom_range(0, 99) < 50);
         ex_rd = AW'($urandom_range(0, 3));
         rs1   = AW'($urandom_range(0, 3));
         rs2   = AW'($urandom_range(0, 3));
         u1    = $urandom_range(0, 1);
         u2    = $urandom_range(0, 1);
      end
      @(posedge clk);
      #1;
      idle(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_ctrl_unit
